// File: rtl/data_mem_bytelane_if.sv
// Request/response bundle between the MEM stage and the byte-lane data memory.
// The master (pipeline) drives address, data and request strobes; the slave
// (memory) returns the extended load result and its status pulses.
interface data_mem_bytelane_if;
  logic [31:0] memLocation;
  logic [31:0] writeData;
  logic        writeEn;
  logic        readEn;
  logic [1:0]  size;
  logic        signedLoad;
  logic [31:0] readData;
  logic        readValid;
  logic        misaligned;
  logic        busy;

  modport master (
    output memLocation, writeData, writeEn, readEn, size, signedLoad,
    input  readData, readValid, misaligned, busy
  );

  modport slave (
    input  memLocation, writeData, writeEn, readEn, size, signedLoad,
    output readData, readValid, misaligned, busy
  );
endinterface

// File: rtl/data_mem_bytelane.sv
// MIPS MEM-stage data memory with per-byte-lane stores and sign/zero-extended
// loads. Loads are registered (one cycle latency, readValid strobe), bad
// alignments are rejected with a misaligned strobe, and reset sweeps every
// word to zero while busy is held high so the pipeline can stall.
module data_mem_bytelane #(
  parameter int DEPTH_WORDS  = 1024,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input logic CLK,
  input logic RST,
  data_mem_bytelane_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state;
  logic [AW-1:0] clrIdx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] wordIdx;
  logic [1:0]    lane;
  logic          aligned;
  logic          accept;
  logic          doWrite;
  logic [3:0]    byteEn;
  logic [31:0]   wrWord;
  logic [31:0]   rdWord;
  logic [31:0]   shifted;
  logic [7:0]    laneByte;
  logic [15:0]   laneHalf;
  logic [31:0]   loadExt;
  logic          unusedAddrBits;

  // Address bits above the array are ignored so addresses alias modulo the memory size
  assign wordIdx        = bus.memLocation[AW+1:2];
  assign lane           = bus.memLocation[1:0];
  assign unusedAddrBits = ^bus.memLocation[31:AW+2];

  assign accept  = (bus.readEn | bus.writeEn) & (state == READY) & ~RST;
  assign doWrite = accept & aligned & bus.writeEn;
  assign bus.busy = (state == CLEAR);

  // Decode alignment, the lanes a store touches, and the lane-replicated store data
  always_comb begin
    aligned = 1'b0;
    byteEn  = 4'b0000;
    wrWord  = bus.writeData;
    case (bus.size)
      2'b00: begin
        aligned = 1'b1;
        byteEn  = 4'b0001 << lane;
        wrWord  = {4{bus.writeData[7:0]}};
      end
      2'b01: begin
        aligned = ~lane[0];
        byteEn  = lane[1] ? 4'b1100 : 4'b0011;
        wrWord  = {2{bus.writeData[15:0]}};
      end
      2'b10: begin
        aligned = (lane == 2'b00);
        byteEn  = 4'b1111;
        wrWord  = bus.writeData;
      end
      default: begin
        aligned = 1'b0;
        byteEn  = 4'b0000;
        wrWord  = bus.writeData;
      end
    endcase
  end

  // Select the addressed lane from the pre-write word and extend it to 32 bits
  always_comb begin
    rdWord   = mem[wordIdx];
    shifted  = rdWord >> {lane, 3'b000};
    laneByte = shifted[7:0];
    laneHalf = lane[1] ? rdWord[31:16] : rdWord[15:0];
    case (bus.size)
      2'b00:   loadExt = {{24{bus.signedLoad & laneByte[7]}}, laneByte};
      2'b01:   loadExt = {{16{bus.signedLoad & laneHalf[15]}}, laneHalf};
      default: loadExt = rdWord;
    endcase
  end

  // Storage: the clear sweep owns the array while busy, otherwise accepted stores write their lanes
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        if (CLEAR_ON_RST) begin
          mem[clrIdx] <= '0;
        end
      end else if (doWrite) begin
        for (int b = 0; b < 4; b++) begin
          if (byteEn[b]) begin
            mem[wordIdx][8*b +: 8] <= wrWord[8*b +: 8];
          end
        end
      end
    end
  end

  // Sweep/ready sequencing plus the registered load result and status pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= CLEAR;
      clrIdx         <= '0;
      bus.readData   <= '0;
      bus.readValid  <= 1'b0;
      bus.misaligned <= 1'b0;
    end else begin
      bus.readValid  <= 1'b0;
      bus.misaligned <= 1'b0;
      case (state)
        CLEAR: begin
          clrIdx <= clrIdx + 1'b1;
          if (!CLEAR_ON_RST || (&clrIdx)) begin
            state <= READY;
          end
        end
        READY: begin
          if (accept) begin
            if (!aligned) begin
              bus.misaligned <= 1'b1;
            end else if (bus.readEn) begin
              bus.readData  <= loadExt;
              bus.readValid <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed bench for data_mem_bytelane: a table of single-cycle accesses with
// hand-computed results, plus hand-written reset/sweep sequences.
module tb_data_mem_bytelane;

  logic CLK;
  logic RST;

  data_mem_bytelane_if memBus ();

  data_mem_bytelane #(
    .DEPTH_WORDS (1024),
    .CLEAR_ON_RST(1'b1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(memBus)
  );

  typedef struct {
    string       name;
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] expData;
    bit          expValid;
    bit          expMis;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Free-running 10-unit clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void addVec(string name, bit re, bit we, logic [31:0] addr,
                                 logic [31:0] wdata, logic [1:0] size, bit sgn,
                                 logic [31:0] expData, bit expValid, bit expMis);
    vec_t v;
    v.name = name; v.re = re; v.we = we; v.addr = addr; v.wdata = wdata;
    v.size = size; v.sgn = sgn; v.expData = expData; v.expValid = expValid;
    v.expMis = expMis;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    memBus.readEn      = 1'b0;
    memBus.writeEn     = 1'b0;
    memBus.memLocation = '0;
    memBus.writeData   = '0;
    memBus.size        = 2'b10;
    memBus.signedLoad  = 1'b0;
  endtask

  // Drive one access for one clock, then sample the registered outputs
  task automatic applyStimulus(vec_t v);
    memBus.readEn      = v.re;
    memBus.writeEn     = v.we;
    memBus.memLocation = v.addr;
    memBus.writeData   = v.wdata;
    memBus.size        = v.size;
    memBus.signedLoad  = v.sgn;
    @(posedge CLK);
    #1;
    idleInputs();
  endtask

  // Count busy cycles while hammering requests that must all be dropped
  task automatic countBusy(output int n, output bit pulseSeen);
    n = 0;
    pulseSeen = 1'b0;
    while (memBus.busy && n < 5000) begin
      n++;
      memBus.readEn      = 1'b1;
      memBus.writeEn     = 1'b1;
      memBus.memLocation = 32'h10;
      memBus.writeData   = 32'hFFFF_FFFF;
      memBus.size        = (n % 2 == 0) ? 2'b11 : 2'b10;
      @(posedge CLK);
      #1;
      if (memBus.readValid || memBus.misaligned) pulseSeen = 1'b1;
    end
    idleInputs();
  endtask

  initial begin
    int n;
    bit pulseSeen;
    vec_t v;

    // Byte loads/stores, half/word alignment, read-before-write and aliasing
    addVec("LW 0x10 cleared",  1, 0, 32'h10,   32'h0,         2'b10, 0, 32'h0000_0000, 1, 0);
    addVec("SW 0x10",          0, 1, 32'h10,   32'h8899_AABB, 2'b10, 0, 32'h0000_0000, 0, 0);
    addVec("LW 0x10",          1, 0, 32'h10,   32'h0,         2'b10, 0, 32'h8899_AABB, 1, 0);
    addVec("LB 0x10",          1, 0, 32'h10,   32'h0,         2'b00, 1, 32'hFFFF_FFBB, 1, 0);
    addVec("LBU 0x13",         1, 0, 32'h13,   32'h0,         2'b00, 0, 32'h0000_0088, 1, 0);
    addVec("LH 0x12",          1, 0, 32'h12,   32'h0,         2'b01, 1, 32'hFFFF_8899, 1, 0);
    addVec("LHU 0x10",         1, 0, 32'h10,   32'h0,         2'b01, 0, 32'h0000_AABB, 1, 0);
    addVec("SB 0x11",          0, 1, 32'h11,   32'hFFFF_FF55, 2'b00, 0, 32'h0000_AABB, 0, 0);
    addVec("LW after SB",      1, 0, 32'h10,   32'h0,         2'b10, 0, 32'h8899_55BB, 1, 0);
    addVec("SH 0x12",          0, 1, 32'h12,   32'hABCD_1234, 2'b01, 0, 32'h8899_55BB, 0, 0);
    addVec("LW after SH",      1, 0, 32'h10,   32'h0,         2'b10, 0, 32'h1234_55BB, 1, 0);
    addVec("LH 0x11 misalign", 1, 0, 32'h11,   32'h0,         2'b01, 1, 32'h1234_55BB, 0, 1);
    addVec("SW 0x12 misalign", 0, 1, 32'h12,   32'hFFFF_FFFF, 2'b10, 0, 32'h1234_55BB, 0, 1);
    addVec("size11 misalign",  1, 1, 32'h10,   32'hFFFF_FFFF, 2'b11, 0, 32'h1234_55BB, 0, 1);
    addVec("idle cycle",       0, 0, 32'h10,   32'h0,         2'b10, 0, 32'h1234_55BB, 0, 0);
    addVec("LW 0x10 intact",   1, 0, 32'h10,   32'h0,         2'b10, 0, 32'h1234_55BB, 1, 0);
    addVec("SW+LW 0x20 rbw",   1, 1, 32'h20,   32'hDEAD_BEEF, 2'b10, 0, 32'h0000_0000, 1, 0);
    addVec("LW 0x20",          1, 0, 32'h20,   32'h0,         2'b10, 0, 32'hDEAD_BEEF, 1, 0);
    addVec("LW 0x1020 alias",  1, 0, 32'h1020, 32'h0,         2'b10, 0, 32'hDEAD_BEEF, 1, 0);
    addVec("SB 0x1023 alias",  0, 1, 32'h1023, 32'h0000_0077, 2'b00, 0, 32'hDEAD_BEEF, 0, 0);
    addVec("LW 0x20 after SB", 1, 0, 32'h20,   32'h0,         2'b10, 0, 32'h77AD_BEEF, 1, 0);
    addVec("LB 0x21",          1, 0, 32'h21,   32'h0,         2'b00, 1, 32'hFFFF_FFBE, 1, 0);
    addVec("LBU 0x22",         1, 0, 32'h22,   32'h0,         2'b00, 0, 32'h0000_00AD, 1, 0);
    addVec("LW top word",      1, 0, 32'hFFFF_FFFC, 32'h0,    2'b10, 0, 32'h0000_0000, 1, 0);
    addVec("SW 0x20 size11",   0, 1, 32'h20,   32'h1111_1111, 2'b11, 0, 32'h0000_0000, 0, 1);
    addVec("LW 0x20 unchanged",1, 0, 32'h20,   32'h0,         2'b10, 0, 32'h77AD_BEEF, 1, 0);
    addVec("LW word signed",   1, 0, 32'h10,   32'h0,         2'b10, 1, 32'h1234_55BB, 1, 0);

    // Reset for one cycle, then the sweep must keep busy high for exactly 1024 cycles
    idleInputs();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    checkOutput("reset readData",   memBus.readData, 32'h0);
    checkOutput("reset readValid",  {31'b0, memBus.readValid}, 32'h0);
    checkOutput("reset misaligned", {31'b0, memBus.misaligned}, 32'h0);
    checkOutput("reset busy",       {31'b0, memBus.busy}, 32'h1);
    countBusy(n, pulseSeen);
    checkOutput("busy cycles", n, 32'd1024);
    checkOutput("pulses while busy", {31'b0, pulseSeen}, 32'h0);

    // Table of single-cycle accesses
    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(v);
      checkOutput({v.name, " readData"},   memBus.readData, v.expData);
      checkOutput({v.name, " readValid"},  {31'b0, memBus.readValid}, {31'b0, v.expValid});
      checkOutput({v.name, " misaligned"}, {31'b0, memBus.misaligned}, {31'b0, v.expMis});
    end

    // Reset landing on a pending load must suppress its readValid
    memBus.readEn      = 1'b1;
    memBus.memLocation = 32'h20;
    memBus.size        = 2'b10;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idleInputs();
    checkOutput("rst on load readValid", {31'b0, memBus.readValid}, 32'h0);
    checkOutput("rst on load readData",  memBus.readData, 32'h0);
    checkOutput("rst on load busy",      {31'b0, memBus.busy}, 32'h1);

    // Let the sweep run 500 cycles, then reset mid-sweep: a full new sweep follows
    for (int c = 0; c < 499; c++) begin
      @(posedge CLK);
    end
    #1;
    checkOutput("busy mid-sweep", {31'b0, memBus.busy}, 32'h1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    countBusy(n, pulseSeen);
    checkOutput("busy cycles after restart", n, 32'd1024);
    checkOutput("pulses during restart", {31'b0, pulseSeen}, 32'h0);

    // Memory written before the resets must now read back as zero
    v.name = "LW 0x20 after reclear"; v.re = 1; v.we = 0; v.addr = 32'h20;
    v.wdata = 32'h0; v.size = 2'b10; v.sgn = 0;
    applyStimulus(v);
    checkOutput("LW 0x20 after reclear data",  memBus.readData, 32'h0);
    checkOutput("LW 0x20 after reclear valid", {31'b0, memBus.readValid}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
